// File: rtl/bsg_dff_reset_rr_share.sv
// Shared reset-able holding register with a round-robin arbiter in front.
// One of els_p requesters is granted whenever the register is free; the held
// word is offered downstream with a valid/yumi handshake plus the winner's index.
module bsg_dff_reset_rr_share #(
    parameter int unsigned  width_p   = 64,
    parameter int unsigned  els_p     = 4,
    localparam int unsigned lg_els_lp = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [els_p-1:0]           yumi_o,

    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [lg_els_lp-1:0]       tag_o,
    input  logic                       yumi_i
);

    logic                 full_r;
    logic [width_p-1:0]   data_r;
    logic [lg_els_lp-1:0] tag_r;
    logic [lg_els_lp-1:0] ptr_r;

    logic                 yumi_eff;
    logic                 free;
    logic                 found;
    logic [lg_els_lp-1:0] win;
    logic [lg_els_lp-1:0] ptr_n;
    int unsigned          idx;

    // A yumi_i without a held word is illegal; ignore it so state cannot corrupt.
    assign yumi_eff = yumi_i & full_r;
    assign free     = ~full_r | yumi_eff;

    // Round-robin scan starting at ptr_r, wrapping modulo els_p.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < els_p; i++) begin
            idx = (32'(ptr_r) + i) % els_p;
            if (!found && v_i[idx]) begin
                found = 1'b1;
                win   = lg_els_lp'(idx);
            end
        end
    end

    // Pointer moves to just past the winner.
    always_comb begin
        ptr_n = (win == lg_els_lp'(els_p - 1)) ? '0 : win + 1'b1;
    end

    // Grant is combinational so a drain and refill can share one cycle.
    always_comb begin
        yumi_o = '0;
        if (!reset_i && free && found) begin
            yumi_o[win] = 1'b1;
        end
    end

    // Holding register and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_r <= 1'b0;
            data_r <= '0;
            tag_r  <= '0;
            ptr_r  <= '0;
        end else if (free) begin
            if (found) begin
                full_r <= 1'b1;
                data_r <= data_i[win*width_p +: width_p];
                tag_r  <= win;
                ptr_r  <= ptr_n;
            end else begin
                full_r <= 1'b0;
            end
        end
    end

    assign v_o    = full_r;
    assign data_o = data_r;
    assign tag_o  = tag_r;

`ifndef SYNTHESIS
    // Consumer must only take a word that is actually present.
    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> full_r)
        else $error("yumi_i asserted while v_o=0");
`endif

endmodule
